// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Sequential restoring (shift-subtract) divider. It resolves one quotient
//   bit per clock and is the inverse of the 8x8 multiplier: a product-sized
//   dividend divided by an operand-sized divisor gives quotient and remainder.
//
// Ports
//   CLOCK_50     in   system clock, all state changes on the rising edge
//   reset        in   synchronous, active-high reset
//   start        in   request, sampled only in IDLE
//   dividend     in   N_W-bit unsigned numerator
//   divisor      in   D_W-bit unsigned denominator
//   quotient     out  N_W-bit registered quotient
//   remainder    out  D_W-bit registered remainder
//   busy         out  high while iterating (RUN)
//   done         out  one-cycle pulse when a result is written
//   div_by_zero  out  set together with the result when divisor was 0
//   dbg_state    out  current FSM state, for observation only
//
// Handshake: a request is taken when start=1 on an edge where the block is
// in IDLE and reset=0. From that edge on, all inputs are ignored until IDLE
// is re-entered; start is never queued. done pulses for exactly one cycle on
// the edge that writes quotient/remainder/div_by_zero, and those outputs
// then hold until the next result write.
// ---------------------------------------------------------------------------
module seq_divider #(
   parameter int N_W = 16,
   parameter int D_W = 8
) (
   input  logic           CLOCK_50,
   input  logic           reset,
   input  logic           start,
   input  logic [N_W-1:0] dividend,
   input  logic [D_W-1:0] divisor,
   output logic [N_W-1:0] quotient,
   output logic [D_W-1:0] remainder,
   output logic           busy,
   output logic           done,
   output logic           div_by_zero,
   output logic [1:0]     dbg_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = $clog2(N_W) + 1;
   localparam int PW = D_W + 1;   // partial remainder width
   localparam int SW = D_W + 2;   // width of the shifted partial

   logic [1:0]     state;
   logic [N_W-1:0] dvd_sh;    // dividend shifting out, quotient shifting in
   logic [D_W-1:0] dsr;       // latched divisor
   logic [PW-1:0]  partial;
   logic [CW-1:0]  count;
   logic           dz_pend;   // divide-by-zero result still to be written

   logic [SW-1:0]  p_shift;
   logic           fits;
   logic [PW-1:0]  p_next;
   logic [N_W-1:0] dvd_next;
   logic           last_iter;

   // One restoring step: bring in the next dividend bit, subtract when the
   // divisor fits. The partial stays below the divisor, so the truncated
   // difference always fits PW bits.
   always_comb begin
      p_shift   = {partial, dvd_sh[N_W-1]};
      fits      = (p_shift >= SW'(dsr));
      p_next    = fits ? PW'(p_shift - SW'(dsr)) : p_shift[PW-1:0];
      dvd_next  = {dvd_sh[N_W-2:0], fits};
      last_iter = (count == CW'(N_W - 1));
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= IDLE;
         dvd_sh      <= '0;
         dsr         <= '0;
         partial     <= '0;
         count       <= '0;
         dz_pend     <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd_sh  <= dividend;
                  dsr     <= divisor;
                  partial <= '0;
                  count   <= '0;
                  if (divisor == '0) begin
                     state   <= DONE;
                     dz_pend <= 1'b1;
                  end else begin
                     state   <= RUN;
                     busy    <= 1'b1;
                     dz_pend <= 1'b0;
                  end
               end
            end
            RUN: begin
               partial <= p_next;
               dvd_sh  <= dvd_next;
               count   <= count + 1'b1;
               if (last_iter) begin
                  quotient    <= dvd_next;
                  remainder   <= p_next[D_W-1:0];
                  div_by_zero <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               // A normal result was already written on entry; a divide by
               // zero writes its saturated result here, one edge after start.
               state <= IDLE;
               if (dz_pend) begin
                  quotient    <= '1;
                  remainder   <= '0;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  dz_pend     <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   logic        CLOCK_50;
   logic        reset;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [1:0]  dbg_state;

   int total = 0;
   int bad   = 0;

   logic [24:0] exp_q[$];   // {div_by_zero, remainder, quotient}

   seq_divider #(.N_W(16), .D_W(8)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // reference model: plain integer division
   function automatic logic [24:0] ref_div(input logic [15:0] a, input logic [7:0] b);
      if (b == 0) return {1'b1, 8'd0, 16'hFFFF};
      return {1'b0, 8'(a % b), 16'(a / b)};
   endfunction

   // driver: one-cycle start pulse, then watch until done (bounded).
   // lat = cycles from start edge to done visible (-1 on timeout).
   task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                         output int lat, output int bcnt, output bit held);
      logic [15:0] q0;
      logic [7:0]  r0;
      @(posedge CLOCK_50); #1;
      dividend = a; divisor = b; start = 1'b1;
      q0 = quotient; r0 = remainder;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      lat = -1; bcnt = 0; held = 1'b1;
      for (int j = 0; j < 40; j++) begin
         @(negedge CLOCK_50);
         if (busy) bcnt++;
         if (done) begin
            lat = j;
            break;
         end
         if (quotient !== q0 || remainder !== r0) held = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge CLOCK_50);
      #1 reset = 1'b0;
      @(negedge CLOCK_50);
      total++; if (quotient !== 16'd0) begin bad++; $display("FAIL reset_quotient got=%0d want=0", quotient); end
      total++; if (remainder !== 8'd0) begin bad++; $display("FAIL reset_remainder got=%0d want=0", remainder); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
   endtask

   task automatic test_basic();
      int lat, bcnt; bit held;
      logic [24:0] e;
      e = ref_div(16'd1234, 8'd7);
      run_op(16'd1234, 8'd7, lat, bcnt, held);
      total++; if (lat !== 16) begin bad++; $display("FAIL basic_latency got=%0d want=16", lat); end
      total++; if (bcnt !== 16) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=16", bcnt); end
      total++; if (quotient !== 16'd176 || quotient !== e[15:0]) begin bad++; $display("FAIL basic_quotient got=%0d want=176", quotient); end
      total++; if (remainder !== 8'd2) begin bad++; $display("FAIL basic_remainder got=%0d want=2", remainder); end
      total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz got=%b want=0", div_by_zero); end
      @(negedge CLOCK_50);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b want=0", done); end
   endtask

   task automatic test_hold();
      int lat, bcnt; bit held;
      run_op(16'd65025, 8'd255, lat, bcnt, held);
      total++; if (quotient !== 16'd255 || remainder !== 8'd0) begin bad++; $display("FAIL hold_first got=%0d r %0d want=255 r 0", quotient, remainder); end
      run_op(16'd5, 8'd9, lat, bcnt, held);
      total++; if (held !== 1'b1) begin bad++; $display("FAIL hold_outputs got=%b want=1", held); end
      total++; if (quotient !== 16'd0 || remainder !== 8'd5) begin bad++; $display("FAIL hold_second got=%0d r %0d want=0 r 5", quotient, remainder); end
   endtask

   task automatic test_div_zero();
      int lat, bcnt; bit held;
      run_op(16'd100, 8'd0, lat, bcnt, held);
      total++; if (lat !== 1) begin bad++; $display("FAIL dz_latency got=%0d want=1", lat); end
      total++; if (bcnt !== 0 || busy !== 1'b0) begin bad++; $display("FAIL dz_busy got=%0d want=0", bcnt); end
      total++; if (quotient !== 16'hFFFF || remainder !== 8'd0) begin bad++; $display("FAIL dz_result got=%h r %0d want=ffff r 0", quotient, remainder); end
      total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dz_flag got=%b want=1", div_by_zero); end
      run_op(16'd100, 8'd10, lat, bcnt, held);
      total++; if (quotient !== 16'd10 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
         bad++; $display("FAIL dz_recover got=%0d r %0d z %b want=10 r 0 z 0", quotient, remainder, div_by_zero); end
   endtask

   task automatic test_ignore_start();
      int dones = 0;
      logic [15:0] q_at_done = '0;
      logic [7:0]  r_at_done = '0;
      @(posedge CLOCK_50); #1;
      dividend = 16'd1234; divisor = 8'd7; start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      for (int j = 0; j < 30; j++) begin
         @(negedge CLOCK_50);
         if (j == 4) begin dividend = 16'd9999; start = 1'b1; end
         if (j == 5) start = 1'b0;
         if (done) begin dones++; q_at_done = quotient; r_at_done = remainder; end
      end
      total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", dones); end
      total++; if (q_at_done !== 16'd176 || r_at_done !== 8'd2) begin bad++; $display("FAIL ignore_result got=%0d r %0d want=176 r 2", q_at_done, r_at_done); end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      int lat, bcnt; bit held;
      @(posedge CLOCK_50); #1;
      dividend = 16'd65535; divisor = 8'd1; start = 1'b1;
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      repeat (8) begin @(negedge CLOCK_50); if (done) dones++; end
      reset = 1'b1;
      @(posedge CLOCK_50); #1;
      reset = 1'b0;
      @(negedge CLOCK_50);
      total++; if (quotient !== 16'd0 || remainder !== 8'd0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
         bad++; $display("FAIL midreset_outputs got=q%0d r%0d b%b z%b want=all 0", quotient, remainder, busy, div_by_zero); end
      repeat (25) begin @(negedge CLOCK_50); if (done) dones++; end
      total++; if (dones !== 0) begin bad++; $display("FAIL midreset_no_done got=%0d want=0", dones); end
      run_op(16'd65535, 8'd1, lat, bcnt, held);
      total++; if (lat !== 16 || quotient !== 16'd65535 || remainder !== 8'd0) begin
         bad++; $display("FAIL midreset_rerun got=%0d r %0d lat %0d want=65535 r 0 lat 16", quotient, remainder, lat); end
   endtask

   task automatic test_back_to_back();
      int when[$];
      @(posedge CLOCK_50); #1;
      dividend = 16'd200; divisor = 8'd3; start = 1'b1;
      for (int j = 0; j < 80; j++) begin
         @(negedge CLOCK_50);
         if (done) begin
            when.push_back(j);
            total++; if (quotient !== 16'd66 || remainder !== 8'd2) begin
               bad++; $display("FAIL b2b_result got=%0d r %0d want=66 r 2", quotient, remainder); end
         end
      end
      start = 1'b0;
      total++; if (when.size() < 4) begin bad++; $display("FAIL b2b_count got=%0d want>=4", when.size()); end
      for (int i = 1; i < when.size(); i++) begin
         total++; if (when[i] - when[i-1] != 18) begin bad++; $display("FAIL b2b_period got=%0d want=18", when[i] - when[i-1]); end
      end
      repeat (25) @(posedge CLOCK_50);
   endtask

   task automatic test_random();
      int lat, bcnt; bit held;
      logic [15:0] a;
      logic [7:0]  b;
      logic [24:0] e;
      for (int i = 0; i < 30; i++) begin
         a = 16'($urandom_range(0, 65535));
         case (i % 10)
            0: b = 8'd0;
            1: b = 8'd1;
            2: b = 8'd255;
            default: b = 8'($urandom_range(1, 255));
         endcase
         if (i % 10 == 3) a = 16'hFFFF;
         exp_q.push_back(ref_div(a, b));
         run_op(a, b, lat, bcnt, held);
         e = exp_q.pop_front();
         total++;
         if (lat !== ((b == 0) ? 1 : 16) || {div_by_zero, remainder, quotient} !== e) begin
            bad++;
            $display("FAIL rand_%0d %0d/%0d got=q%0d r%0d z%b lat%0d want=q%0d r%0d z%b", i, a, b,
                     quotient, remainder, div_by_zero, lat, e[15:0], e[23:16], e[24]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
